// File: rtl/if_pkg.sv
// Purpose: shared types and defaults for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    // Fetch controller states: issuing, discarding a redirected fetch, skid occupied.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DROP = 2'd1,
        FULL = 2'd2
    } fetch_state_e;

    // Instruction word paired with its fall-through address.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } fetch_word_t;

    localparam logic [31:0] IF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

    // Sequential next address; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Purpose: instruction memory read bus between fetch stage and memory.
// Latency: n/a (wiring only).
// Backpressure: requester holds req/addr stable until ready is seen.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_skid_reg.sv
// Purpose: 64-bit load/hold register holding one skidded instruction + npc.
// Latency: 1 cycle from load to q.
// Backpressure: none; holds value while load is low.
module if_skid_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] d,
    output logic [63:0] q
);

    logic [63:0] data_q;
    logic [63:0] data_d;

    // Capture on load, otherwise keep the parked word.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = d;
        end
    end

    // Skid storage register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 64'd0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/if_fetch.sv
// Purpose: instruction fetch stage with redirect handling and a one-entry skid; optional IF_ALIGN_CHK_EN adds misalign_err.
// Latency: 1 cycle from imem_ready to instr_valid; one instruction per cycle with zero-wait memory.
// Backpressure: stall parks one returned word in the skid and drops imem_req until the output slot frees.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    if_fetch_if.master  imem,
    output logic [31:0] instr,
    output logic [31:0] npc,
    output logic        instr_valid
`ifdef IF_ALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  npc_q, npc_d;
    logic         instr_valid_q, instr_valid_d;

    logic         skid_load;
    fetch_word_t  skid_in;
    fetch_word_t  skid_out;

    logic [31:0]  pc_plus4;
    logic [31:0]  redir_tgt;
    logic         slot_free;

`ifdef IF_ALIGN_CHK_EN
    logic         misalign_err_q, misalign_err_d;
    // Misaligned targets are forced onto a word boundary.
    assign redir_tgt = {redirect_pc[31:2], 2'b00};
`else
    assign redir_tgt = redirect_pc;
`endif

    assign pc_plus4  = pc_inc(pc_q);
    assign slot_free = !instr_valid_q || !stall;

    assign skid_in.instr = imem.imem_rdata;
    assign skid_in.npc   = pc_plus4;

    if_skid_reg u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .d     (skid_in),
        .q     (skid_out)
    );

    // Next-state and datapath updates for the fetch controller.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        npc_d         = npc_q;
        instr_valid_d = instr_valid_q;
        skid_load     = 1'b0;
`ifdef IF_ALIGN_CHK_EN
        misalign_err_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

        // A consumed slot empties unless something below refills it.
        if (instr_valid_q && !stall) begin
            instr_valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    if (imem.imem_ready) begin
                        pc_d = redir_tgt;
                    end else begin
                        // Outstanding request must complete before retargeting.
                        pend_pc_d = redir_tgt;
                        state_d   = DROP;
                    end
                end else if (imem.imem_ready) begin
                    pc_d = pc_plus4;
                    if (slot_free) begin
                        instr_d       = imem.imem_rdata;
                        npc_d         = pc_plus4;
                        instr_valid_d = 1'b1;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pend_pc_d     = redir_tgt;
                end
                if (imem.imem_ready) begin
                    pc_d    = redirect_valid ? redir_tgt : pend_pc_q;
                    state_d = RUN;
                end
            end
            FULL: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redir_tgt;
                    state_d       = RUN;
                end else if (!stall) begin
                    instr_d       = skid_out.instr;
                    npc_d         = skid_out.npc;
                    instr_valid_d = 1'b1;
                    state_d       = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pend_pc_q     <= 32'd0;
            instr_q       <= NOP_INSTR;
            npc_q         <= 32'd0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            instr_q       <= instr_d;
            npc_q         <= npc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef IF_ALIGN_CHK_EN
    // One-cycle pulse following a misaligned redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end
    assign misalign_err = misalign_err_q;
`endif

    // Request is suppressed during reset so an abandoned fetch is dropped at once.
    assign imem.imem_req  = rst_n && (state_q != FULL);
    assign imem.imem_addr = pc_q;

    assign instr       = instr_valid_q ? instr_q : NOP_INSTR;
    assign npc         = npc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Purpose: directed self-checking bench for if_fetch.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: exercised via stall, delayed ready and redirects.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_ALIGN_CHK_EN
    localparam logic [31:0] MIS_T = 32'h0000_0100;
`else
    localparam logic [31:0] MIS_T = 32'h0000_0102;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        instr_valid;
`ifdef IF_ALIGN_CHK_EN
    logic        misalign_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    if_fetch_if mem ();

    // Memory returns a word tagged with the low half of its address.
    assign mem.imem_ready = ready;
    assign mem.imem_rdata = {16'hC0DE, mem.imem_addr[15:0]};

    if_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (mem),
        .instr          (instr),
        .npc            (npc),
        .instr_valid    (instr_valid)
`ifdef IF_ALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Address is only meaningful while a request is raised.
    task automatic outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                        input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_npc);
        chk1({tag, "_req"}, mem.imem_req, e_req);
        if (e_req) chk32({tag, "_addr"}, mem.imem_addr, e_addr);
        chk1({tag, "_vld"}, instr_valid, e_vld);
        chk32({tag, "_instr"}, instr, e_instr);
        chk32({tag, "_npc"}, npc, e_npc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outs("rst", 1'b0, 32'd0, 1'b0, NOP, 32'd0);
`ifdef IF_ALIGN_CHK_EN
        chk1("rst_mis", misalign_err, 1'b0);
`endif

        // Streaming with zero-wait memory.
        rst_n = 1'b1; #1;
        outs("c1", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        tick(); outs("c2", 1'b1, 32'h4, 1'b1, 32'hC0DE_0000, 32'h4);
        tick(); outs("c3", 1'b1, 32'h8, 1'b1, 32'hC0DE_0004, 32'h8);

        // Three wait cycles on address 8.
        ready = 1'b0;
        tick(); outs("w1", 1'b1, 32'h8, 1'b0, NOP, 32'h8);
        tick(); outs("w2", 1'b1, 32'h8, 1'b0, NOP, 32'h8);
        tick(); outs("w3", 1'b1, 32'h8, 1'b0, NOP, 32'h8);
        ready = 1'b1;
        tick(); outs("w4", 1'b1, 32'hC, 1'b1, 32'hC0DE_0008, 32'hC);

        // Two stall cycles: word C goes to the skid.
        stall = 1'b1;
        tick(); outs("s1", 1'b0, 32'h10, 1'b1, 32'hC0DE_0008, 32'hC);
        tick(); outs("s2", 1'b0, 32'h10, 1'b1, 32'hC0DE_0008, 32'hC);
        stall = 1'b0;
        tick(); outs("s3", 1'b1, 32'h10, 1'b1, 32'hC0DE_000C, 32'h10);

        // Redirect while the fetch of 0x10 is still waiting.
        ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick(); outs("d1", 1'b1, 32'h10, 1'b0, NOP, 32'h10);
        redirect_valid = 1'b0; ready = 1'b1;
        tick(); outs("d2", 1'b1, 32'h100, 1'b0, NOP, 32'h10);
        tick(); outs("d3", 1'b1, 32'h104, 1'b1, 32'hC0DE_0100, 32'h104);

        // Misaligned redirect target.
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick(); outs("m1", 1'b1, MIS_T, 1'b0, NOP, 32'h104);
`ifdef IF_ALIGN_CHK_EN
        chk1("m1_mis", misalign_err, 1'b1);
`endif
        redirect_valid = 1'b0;
        tick(); outs("m2", 1'b1, MIS_T + 32'd4, 1'b1, {16'hC0DE, MIS_T[15:0]}, MIS_T + 32'd4);
`ifdef IF_ALIGN_CHK_EN
        chk1("m2_mis", misalign_err, 1'b0);
`endif

        // pc+4 wraps at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick(); outs("wr1", 1'b1, 32'hFFFF_FFFC, 1'b0, NOP, MIS_T + 32'd4);
        redirect_valid = 1'b0;
        tick(); outs("wr2", 1'b1, 32'h0, 1'b1, 32'hC0DE_FFFC, 32'h0);

        // Redirect while FULL and stalled: flush wins over stall.
        stall = 1'b1;
        tick(); outs("f1", 1'b0, 32'h4, 1'b1, 32'hC0DE_FFFC, 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); outs("f2", 1'b1, 32'h200, 1'b0, NOP, 32'h0);
        redirect_valid = 1'b0; stall = 1'b0;
        tick(); outs("f3", 1'b1, 32'h204, 1'b1, 32'hC0DE_0200, 32'h204);

        // Reset asserted in the middle of a DROP.
        ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick(); outs("r1", 1'b1, 32'h204, 1'b0, NOP, 32'h204);
        redirect_valid = 1'b0;
        #2; rst_n = 1'b0; #1;
        outs("r2", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
`ifdef IF_ALIGN_CHK_EN
        chk1("r2_mis", misalign_err, 1'b0);
`endif
        ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        outs("r3", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        tick(); outs("r4", 1'b1, 32'h4, 1'b1, 32'hC0DE_0000, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
